// File: rtl/div_pkg.sv
// Shared encodings for the EXE-stage divider sequencing controller.
// The op encodings, the FSM state type and the divider's fixed latency live here.
package div_pkg;

    localparam logic [1:0] OP_DIV_W  = 2'b00;
    localparam logic [1:0] OP_MOD_W  = 2'b01;
    localparam logic [1:0] OP_DIV_WU = 2'b10;
    localparam logic [1:0] OP_MOD_WU = 2'b11;

    localparam int DIV_LATENCY = 33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/div_ctrl.sv
// Sequences one divide/modulo request through the non-cancellable iterative divider.
// A flushed operation is drained to completion and its result is discarded.
module div_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic [TAG_W-1:0] resp_tag,
    input  logic             flush,
    output logic             busy,
    output logic             div_en,
    output logic             div_signed,
    output logic [31:0]      div_x,
    output logic [31:0]      div_y,
    input  logic [31:0]      div_s,
    input  logic [31:0]      div_r,
    input  logic             div_complete
);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_x;
    logic [31:0]        r_y;
    logic [1:0]         r_op;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_result;
    logic               w_accept;
    logic               w_capture;

    assign w_accept  = (r_state == ST_IDLE) && req_valid && !flush;
    assign w_capture = (r_state == ST_BUSY) && div_complete && !flush;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && !flush) w_next = ST_BUSY;
                else                     w_next = ST_IDLE;
            end
            ST_BUSY: begin
                // A flush landing on the completion cycle has nothing left to drain.
                if (flush && div_complete) w_next = ST_IDLE;
                else if (flush)            w_next = ST_DRAIN;
                else if (div_complete)     w_next = ST_DONE;
                else                       w_next = ST_BUSY;
            end
            ST_DRAIN: begin
                if (div_complete) w_next = ST_IDLE;
                else              w_next = ST_DRAIN;
            end
            ST_DONE: begin
                if (flush || resp_ready) w_next = ST_IDLE;
                else                     w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch on accept; operands stay frozen because the divider re-reads sign bits at the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x   <= 32'd0;
            r_y   <= 32'd0;
            r_op  <= 2'b00;
            r_tag <= '0;
        end else if (w_accept) begin
            r_x   <= req_x;
            r_y   <= req_y;
            r_op  <= req_op;
            r_tag <= req_tag;
        end else begin
            r_x   <= r_x;
            r_y   <= r_y;
            r_op  <= r_op;
            r_tag <= r_tag;
        end
    end

    // Result capture: remainder for mod ops, quotient for div ops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= 32'd0;
        end else if (w_capture) begin
            r_result <= r_op[0] ? div_r : div_s;
        end else begin
            r_result <= r_result;
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign div_en      = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
    assign div_signed  = ~r_op[1];
    assign div_x       = r_x;
    assign div_y       = r_y;
    assign resp_result = r_result;
    assign resp_tag    = r_tag;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural 33-cycle divider alongside.
// Table-driven basic ops plus hand-written flush, stall, back-to-back and reset sequences.
module tb_div_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_tag;
    logic        flush;
    logic        busy;
    logic        div_en;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic [31:0] div_s;
    logic [31:0] div_r;
    logic        div_complete;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int t_acc   = 0;

    div_ctrl #(.TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag),
        .flush(flush), .busy(busy), .div_en(div_en), .div_signed(div_signed),
        .div_x(div_x), .div_y(div_y), .div_s(div_s), .div_r(div_r),
        .div_complete(div_complete)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: counter starts at 0 when div_en rises, completes when it reaches 33.
    logic [5:0] m_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         m_cnt <= 6'd0;
        else if (!div_en || m_cnt == 6'd33) m_cnt <= 6'd0;
        else                               m_cnt <= m_cnt + 6'd1;
    end
    assign div_complete = div_en && (m_cnt == 6'd33);

    always_comb begin
        div_s = 32'd0;
        div_r = 32'd0;
        if (div_y == 32'd0) begin
            div_s = 32'hFFFF_FFFF;
            div_r = div_x;
        end else if (div_signed) begin
            div_s = $signed(div_x) / $signed(div_y);
            div_r = $signed(div_x) % $signed(div_y);
        end else begin
            div_s = div_x / div_y;
            div_r = div_x % div_y;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    // Presents one request and returns just after the accepting edge.
    task automatic do_req(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] tag);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_tag = tag;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        t_acc = cyc + 1;
        #1 req_valid = 1'b0;
    endtask

    // Waits (bounded) for resp_valid, sampling on the falling edge; lat=-1 on timeout.
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = cyc - t_acc;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int  lat;
        bit  ok;
        bit  seen;
        int  t_idle;
        int  t_rdy;
        logic [31:0] hold_res;
        logic [4:0]  hold_tag;

        vecs[0] = '{OP_DIV_W,  32'hFFFF_FFF9, 32'd2, 5'd3,  32'hFFFF_FFFD};
        vecs[1] = '{OP_MOD_W,  32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFF};
        vecs[2] = '{OP_DIV_WU, 32'hFFFF_FFF9, 32'd2, 5'd31, 32'h7FFF_FFFC};
        vecs[3] = '{OP_MOD_WU, 32'd100,       32'd7, 5'd9,  32'h0000_0002};

        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_x = 32'd0; req_y = 32'd0;
        req_tag = 5'd0; resp_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_div_en",     {31'd0, div_en},     32'd0);
        check("rst_div_x",      div_x,               32'd0);
        check("rst_result",     resp_result,         32'd0);

        // Basic operations with resp_ready high.
        for (int i = 0; i < 4; i++) begin
            do_req(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].tag);
            wait_resp(lat);
            check($sformatf("vec%0d_latency", i), lat,                   32'd34);
            check($sformatf("vec%0d_result", i),  resp_result,           vecs[i].exp);
            check($sformatf("vec%0d_tag", i),     {27'd0, resp_tag},     {27'd0, vecs[i].tag});
            @(posedge clk);
        end

        // Flush 10 cycles after accept: drained with div_en/busy high, no response.
        do_req(OP_DIV_W, 32'd20, 32'd4, 5'd5);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        ok = 1'b1; seen = 1'b0; t_idle = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            flush = (n == 5);
            if (resp_valid) seen = 1'b1;
            if (!busy) begin
                t_idle = cyc - t_acc;
                break;
            end
            if (!div_en) ok = 1'b0;
        end
        flush = 1'b0;
        check("flush_drain_en",   {31'd0, ok},   32'd1);
        check("flush_no_resp",    {31'd0, seen}, 32'd0);
        check("flush_idle_cycle", t_idle,        32'd34);
        do_req(OP_DIV_W, 32'd9, 32'd3, 5'd12);
        wait_resp(lat);
        check("after_flush_result", resp_result, 32'd3);
        check("after_flush_lat",    lat,         32'd34);
        @(posedge clk);

        // Flush coincident with div_complete.
        do_req(OP_DIV_WU, 32'd50, 32'd5, 5'd7);
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (div_complete) begin
                seen = 1'b1;
                break;
            end
        end
        check("coinc_complete_seen", {31'd0, seen}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("coinc_busy",      {31'd0, busy},       32'd0);
        check("coinc_req_ready", {31'd0, req_ready},  32'd1);
        check("coinc_div_en",    {31'd0, div_en},     32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("coinc_no_resp", {31'd0, seen}, 32'd0);

        // Consumer stalls 5 cycles in DONE.
        resp_ready = 1'b0;
        do_req(OP_MOD_W, 32'd23, 32'd5, 5'd21);
        wait_resp(lat);
        check("stall_result", resp_result, 32'd3);
        hold_res = resp_result; hold_tag = resp_tag;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!resp_valid || resp_result !== hold_res || resp_tag !== hold_tag ||
                req_ready || div_en) ok = 1'b0;
        end
        check("stall_stable", {31'd0, ok},       32'd1);
        check("stall_tag",    {27'd0, hold_tag}, 32'd21);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_released", {31'd0, resp_valid}, 32'd0);

        // Back-to-back: the second request waits for req_ready, 35 cycles after the first accept.
        do_req(OP_DIV_W, 32'd6, 32'd3, 5'd1);
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MOD_W; req_x = 32'd7; req_y = 32'd3; req_tag = 5'd2;
        hold_res = 32'hDEAD_BEEF; t_rdy = -1;
        for (int n = 0; n < 60; n++) begin
            if (resp_valid) hold_res = resp_result;
            if (req_ready) begin
                t_rdy = cyc - t_acc;
                break;
            end
            @(negedge clk);
        end
        check("b2b_first_result", hold_res, 32'd2);
        check("b2b_spacing",      t_rdy,    32'd35);
        @(posedge clk);
        t_acc = cyc + 1;
        #1 req_valid = 1'b0;
        wait_resp(lat);
        check("b2b_second_result", resp_result,        32'd1);
        check("b2b_second_tag",    {27'd0, resp_tag},  32'd2);
        @(posedge clk);

        // Reset pulse mid-BUSY.
        do_req(OP_DIV_W, 32'd77, 32'd7, 5'd14);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy",   {31'd0, busy},   32'd0);
        check("mid_rst_div_en", {31'd0, div_en}, 32'd0);
        check("mid_rst_div_x",  div_x,           32'd0);
        check("mid_rst_tag",    {27'd0, resp_tag}, 32'd0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid || busy) seen = 1'b1;
        end
        check("mid_rst_no_resp", {31'd0, seen}, 32'd0);
        do_req(OP_DIV_W, 32'd8, 32'd2, 5'd4);
        wait_resp(lat);
        check("post_rst_result", resp_result, 32'd4);
        check("post_rst_lat",    lat,         32'd34);
        @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
